// File: rtl/delay_detect.sv
// delay_detect: recovers the delay between a reference bit stream and its delayed copy
module delay_detect #(
    parameter int MAX_DELAY = 7,
    parameter int AW        = 3,
    parameter int WINDOW    = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          Din,
    input  logic          Dly,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] addr,
    output logic          locked,
    output logic          ambig
);
    localparam int CNTW = $clog2(WINDOW + 1);
    localparam int CW   = $clog2(WINDOW + MAX_DELAY + 1);

    typedef enum logic [2:0] {IDLE, FLUSH, MEASURE, RESOLVE, DONE} state_t;

    state_t              state, nxt;
    logic [CW-1:0]       ctr;
    logic [MAX_DELAY-1:0] hist;
    logic [MAX_DELAY:0]  taps;
    logic [CNTW-1:0]     cnt [MAX_DELAY+1];
    logic [CNTW-1:0]     cur, best_cnt, nb_cnt;
    logic [AW-1:0]       best_idx, nb_idx;
    logic [1:0]          zeros, nz;
    logic                first, take;

    assign taps = {hist, Din};
    assign busy = state == FLUSH || state == MEASURE || state == RESOLVE;
    assign done = state == DONE;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? FLUSH : IDLE;
            FLUSH:   nxt = ctr == CW'(MAX_DELAY - 1) ? MEASURE : FLUSH;
            MEASURE: nxt = ctr == CW'(WINDOW - 1) ? RESOLVE : MEASURE;
            RESOLVE: nxt = ctr == CW'(MAX_DELAY) ? DONE : RESOLVE;
            default: nxt = IDLE;
        endcase
    end

    // Sequential scan: candidate ctr is compared against the running best
    always_comb begin
        cur = '0;
        for (int i = 0; i <= MAX_DELAY; i++)
            if (ctr == CW'(i)) cur = cnt[i];
        first  = ctr == '0;
        take   = first || cur < best_cnt;
        nb_cnt = take ? cur : best_cnt;
        nb_idx = take ? AW'(ctr) : best_idx;
        nz     = first ? 2'd0 : zeros;
        if (cur == '0 && nz != 2'd2) nz = nz + 2'd1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            ctr   <= '0;
            hist  <= '0;
        end else begin
            state <= nxt;
            ctr   <= (nxt != state || state == IDLE) ? '0 : ctr + 1'b1;
            hist  <= {hist[MAX_DELAY-2:0], Din};
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int k = 0; k <= MAX_DELAY; k++) cnt[k] <= '0;
        end else if (state == IDLE && start) begin
            for (int k = 0; k <= MAX_DELAY; k++) cnt[k] <= '0;
        end else if (state == MEASURE) begin
            for (int k = 0; k <= MAX_DELAY; k++)
                if (taps[k] != Dly && cnt[k] != '1) cnt[k] <= cnt[k] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            best_cnt <= '0;
            best_idx <= '0;
            zeros    <= '0;
            addr     <= '0;
            locked   <= 1'b0;
            ambig    <= 1'b0;
        end else if (state == RESOLVE) begin
            best_cnt <= nb_cnt;
            best_idx <= nb_idx;
            zeros    <= nz;
            if (ctr == CW'(MAX_DELAY)) begin
                addr   <= nb_idx;
                locked <= nb_cnt == '0;
                ambig  <= nz == 2'd2;
            end
        end
    end
endmodule

// File: tb/tb_delay_detect.sv
// tb_delay_detect: directed measurements checked by a done-driven scoreboard
module tb_delay_detect;
    logic       clk = 1'b0, clr = 1'b1, start = 1'b0, Din = 1'b0, Dly = 1'b0;
    logic       busy, done, locked, ambig;
    logic [2:0] addr;

    typedef struct {
        int a;
        int l;
        int am;
        int c;
    } exp_t;

    exp_t  q[$];
    int    cyc = 0, checks = 0, passes = 0;
    int    dsel = 0, inv_at = -1, n = 0;
    bit    zero_mode = 1'b0;
    logic [15:0] dh = '0;
    logic [6:0]  prbs = 7'h7F;

    delay_detect dut (
        .clk(clk), .clr(clr), .start(start), .Din(Din), .Dly(Dly),
        .busy(busy), .done(done), .addr(addr), .locked(locked), .ambig(ambig)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Stream driver: dh[j] is Din from j cycles ago
    initial begin
        forever begin
            @(posedge clk);
            #1;
            prbs = {prbs[5:0], prbs[6] ^ prbs[5]};
            dh   = {dh[14:0], zero_mode ? 1'b0 : prbs[0]};
            Din  = dh[0];
            Dly  = dh[dsel] ^ (cyc == inv_at);
        end
    end

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("addr", int'(addr), e.a);
                chk("locked", int'(locked), e.l);
                chk("ambig", int'(ambig), e.am);
                chk("done_cycle", cyc, e.c);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = cyc;
    endtask

    task automatic measure(input int d, input bit zm, input int inv_off,
                           input int ea, input int el, input int eam, input bit extra);
        dsel = d;
        zero_mode = zm;
        repeat (3) @(posedge clk);
        pulse_start();
        inv_at = inv_off >= 0 ? n + inv_off : -1;
        q.push_back('{ea, el, eam, n + 47});
        if (extra) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (23) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        chk("pending_results", q.size(), 0);
        q.delete();
        @(posedge clk);
        #1;
        chk("busy_after_done", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
        inv_at = -1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_ambig", int'(ambig), 0);
        clr = 1'b0;
        measure(3, 1'b0, -1, 3, 1, 0, 1'b0);
        measure(3, 1'b0, -1, 3, 1, 0, 1'b1);
        measure(0, 1'b0, -1, 0, 1, 0, 1'b0);
        measure(0, 1'b1, -1, 0, 1, 1, 1'b0);
        measure(5, 1'b0, 20, 5, 0, 0, 1'b0);
        measure(7, 1'b0, -1, 7, 1, 0, 1'b0);
        dsel = 3;
        zero_mode = 1'b0;
        pulse_start();
        repeat (19) @(posedge clk);
        #1 clr = 1'b1;
        #1;
        chk("clr_busy", int'(busy), 0);
        chk("clr_done", int'(done), 0);
        chk("clr_addr", int'(addr), 0);
        chk("clr_locked", int'(locked), 0);
        chk("clr_ambig", int'(ambig), 0);
        @(posedge clk);
        #1 clr = 1'b0;
        repeat (60) @(posedge clk);
        measure(2, 1'b0, -1, 2, 1, 0, 1'b0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
